// File: rtl/arrow_scheduler.sv
// Rhythm-game arrow sequencer: generates LFSR-driven arrow codes, scrolls them
// toward the hit slot once per scroll step, judges presses and tracks combos.
module arrow_scheduler #(
    parameter int         NUM_SLOTS  = 4,
    parameter int         TICK_DIV   = 25_000_000,
    parameter int         COMBO_BITS = 8,
    parameter logic [5:0] LFSR_SEED  = 6'h2D
) (
    input  logic                    clk,
    input  logic                    arst_i,
    input  logic [1:0]              state_i,
    input  logic [3:0]              btn_i,
    output logic [5*NUM_SLOTS-1:0]  slots_o,
    output logic [COMBO_BITS-1:0]   combo_o,
    output logic [COMBO_BITS-1:0]   max_combo_o,
    output logic                    hit_o,
    output logic                    miss_o,
    output logic                    step_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]             CODE_NONE  = 5'd20;
    localparam logic [5*NUM_SLOTS-1:0] SLOTS_NONE = {NUM_SLOTS{5'd20}};
    localparam logic [COMBO_BITS-1:0]  COMBO_MAX  = {COMBO_BITS{1'b1}};
    localparam logic [1:0]             ST_GAME    = 2'd0;
    localparam logic [1:0]             ST_RESET   = 2'd2;

    // Required button mask {up,down,left,right} for an arrow code.
    function automatic logic [3:0] arrow_mask(input logic [4:0] code);
        case (code)
            5'd10:   arrow_mask = 4'b1000;
            5'd11:   arrow_mask = 4'b0100;
            5'd12:   arrow_mask = 4'b0010;
            5'd13:   arrow_mask = 4'b0001;
            5'd14:   arrow_mask = 4'b1100;
            5'd15:   arrow_mask = 4'b1010;
            5'd16:   arrow_mask = 4'b1001;
            5'd17:   arrow_mask = 4'b0110;
            5'd18:   arrow_mask = 4'b0101;
            5'd19:   arrow_mask = 4'b0011;
            default: arrow_mask = 4'b0000;
        endcase
    endfunction

    // Upper LFSR nibble selects an arrow; values above 10 produce an empty slot.
    function automatic logic [4:0] arrow_code(input logic [5:0] q);
        logic [3:0] v;
        v = q[5:2];
        if (v <= 4'd10) begin
            arrow_code = 5'd10 + {1'b0, v};
        end else begin
            arrow_code = CODE_NONE;
        end
    endfunction

    function automatic logic [5:0] lfsr_next(input logic [5:0] q);
        lfsr_next = {q[4:0], q[5] ^ q[4]};
    endfunction

    logic [CNT_W-1:0]       cnt_r,     cnt_s;
    logic [5:0]             lfsr_r,    lfsr_s;
    logic [3:0]             pressed_r, pressed_s;
    logic [5*NUM_SLOTS-1:0] slots_r,   slots_s;
    logic [COMBO_BITS-1:0]  combo_r,   combo_s;
    logic [COMBO_BITS-1:0]  max_r,     max_s;
    logic                   hit_r,     hit_s;
    logic                   miss_r,    miss_s;
    logic                   step_r,    step_s;
    logic [3:0]             judge_s;
    logic [3:0]             req_s;
    logic [COMBO_BITS-1:0]  combo_inc_s;

    // Next-state: counting, judging at a step, scrolling, and the RESET game state.
    always_comb begin
        cnt_s       = cnt_r;
        lfsr_s      = lfsr_r;
        pressed_s   = pressed_r;
        slots_s     = slots_r;
        combo_s     = combo_r;
        max_s       = max_r;
        hit_s       = 1'b0;
        miss_s      = 1'b0;
        step_s      = 1'b0;
        // A press landing on the step cycle itself still counts for the outgoing arrow.
        judge_s     = pressed_r | btn_i;
        req_s       = arrow_mask(slots_r[4:0]);
        combo_inc_s = (combo_r == COMBO_MAX) ? combo_r : combo_r + COMBO_BITS'(1);

        case (state_i)
            ST_GAME: begin
                if (cnt_r == CNT_LAST) begin
                    step_s    = 1'b1;
                    cnt_s     = {CNT_W{1'b0}};
                    pressed_s = 4'b0000;
                    lfsr_s    = lfsr_next(lfsr_r);
                    if (req_s != 4'b0000) begin
                        if (judge_s == req_s) begin
                            hit_s   = 1'b1;
                            combo_s = combo_inc_s;
                            if (combo_inc_s > max_r) begin
                                max_s = combo_inc_s;
                            end else begin
                                max_s = max_r;
                            end
                        end else begin
                            miss_s  = 1'b1;
                            combo_s = {COMBO_BITS{1'b0}};
                        end
                    end else if (judge_s != 4'b0000) begin
                        miss_s  = 1'b1;
                        combo_s = {COMBO_BITS{1'b0}};
                    end else begin
                        combo_s = combo_r;
                    end
                    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                        slots_s[5*i +: 5] = slots_r[5*(i+1) +: 5];
                    end
                    slots_s[5*(NUM_SLOTS-1) +: 5] = arrow_code(lfsr_r);
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                    pressed_s = pressed_r | btn_i;
                end
            end
            ST_RESET: begin
                cnt_s     = {CNT_W{1'b0}};
                slots_s   = SLOTS_NONE;
                lfsr_s    = LFSR_SEED;
                pressed_s = 4'b0000;
                combo_s   = {COMBO_BITS{1'b0}};
            end
            default: begin
                cnt_s = cnt_r;
            end
        endcase
    end

    // State and output registers; arst_i clears everything including the best combo.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            cnt_r     <= {CNT_W{1'b0}};
            lfsr_r    <= LFSR_SEED;
            pressed_r <= 4'b0000;
            slots_r   <= SLOTS_NONE;
            combo_r   <= {COMBO_BITS{1'b0}};
            max_r     <= {COMBO_BITS{1'b0}};
            hit_r     <= 1'b0;
            miss_r    <= 1'b0;
            step_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            lfsr_r    <= lfsr_s;
            pressed_r <= pressed_s;
            slots_r   <= slots_s;
            combo_r   <= combo_s;
            max_r     <= max_s;
            hit_r     <= hit_s;
            miss_r    <= miss_s;
            step_r    <= step_s;
        end
    end

    assign slots_o     = slots_r;
    assign combo_o     = combo_r;
    assign max_combo_o = max_r;
    assign hit_o       = hit_r;
    assign miss_o      = miss_r;
    assign step_o      = step_r;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: directed scenarios plus a randomized
// run, all compared against an array/integer reference model of the game rules.
module tb_arrow_scheduler;

    localparam int NS = 4;
    localparam int TD = 4;
    localparam int CB = 3;
    localparam int AW = 5*NS + 2*CB + 3;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [1:0]      state = 2'd0;
    logic [3:0]      btn = 4'b0000;
    logic [5*NS-1:0] slots_o;
    logic [CB-1:0]   combo_o;
    logic [CB-1:0]   max_combo_o;
    logic            hit_o;
    logic            miss_o;
    logic            step_o;
    logic [AW-1:0]   dut_all;

    arrow_scheduler #(
        .NUM_SLOTS  (NS),
        .TICK_DIV   (TD),
        .COMBO_BITS (CB),
        .LFSR_SEED  (6'h2D)
    ) dut (
        .clk         (clk),
        .arst_i      (arst),
        .state_i     (state),
        .btn_i       (btn),
        .slots_o     (slots_o),
        .combo_o     (combo_o),
        .max_combo_o (max_combo_o),
        .hit_o       (hit_o),
        .miss_o      (miss_o),
        .step_o      (step_o)
    );

    always #5 clk = ~clk;

    assign dut_all = {slots_o, combo_o, max_combo_o, hit_o, miss_o, step_o};

    // Reference model state
    int m_slots[NS];
    int m_cnt, m_lfsr, m_pressed, m_combo, m_max;
    bit e_hit, e_miss, e_step;
    int masks[11] = '{8, 4, 2, 1, 12, 10, 9, 6, 5, 3, 0};
    int vectors = 0;
    int errors = 0;

    function automatic int mask_of(input int code);
        if (code >= 10 && code <= 20) return masks[code-10];
        return 0;
    endfunction

    function automatic logic [AW-1:0] exp_all();
        logic [5*NS-1:0] s;
        for (int i = 0; i < NS; i++) s[5*i +: 5] = 5'(m_slots[i]);
        return {s, CB'(m_combo), CB'(m_max), e_hit, e_miss, e_step};
    endfunction

    task automatic model_arst();
        for (int i = 0; i < NS; i++) m_slots[i] = 20;
        m_cnt = 0; m_lfsr = 'h2D; m_pressed = 0; m_combo = 0; m_max = 0;
        e_hit = 0; e_miss = 0; e_step = 0;
    endtask

    task automatic model_clock(input int st, input int b);
        int m, req, v;
        e_hit = 0; e_miss = 0; e_step = 0;
        if (st == 2) begin
            for (int i = 0; i < NS; i++) m_slots[i] = 20;
            m_cnt = 0; m_lfsr = 'h2D; m_pressed = 0; m_combo = 0;
        end else if (st == 0) begin
            if (m_cnt == TD-1) begin
                e_step = 1;
                m = m_pressed | b;
                req = mask_of(m_slots[0]);
                if (req != 0 && m == req) begin
                    e_hit = 1;
                    if (m_combo < (1 << CB) - 1) m_combo++;
                    if (m_combo > m_max) m_max = m_combo;
                end else if (m != 0 || req != 0) begin
                    e_miss = 1;
                    m_combo = 0;
                end
                v = m_lfsr >> 2;
                for (int i = 0; i < NS-1; i++) m_slots[i] = m_slots[i+1];
                m_slots[NS-1] = (v <= 10) ? 10 + v : 20;
                m_lfsr = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
                m_pressed = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
                m_pressed |= b;
            end
        end
    endtask

    task automatic apply(input logic [1:0] st, input logic [3:0] b);
        state = st;
        btn = b;
        @(posedge clk);
        model_clock(int'(st), int'(b));
        #1;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        arst = 1'b1;
        state = 2'd0;
        btn = 4'b0000;
        model_arst();
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5*NS-1:0] none_s;
        none_s = {NS{5'd20}};
        model_arst();
        #12;
        vectors++;
        if (dut_all !== exp_all()) begin
            errors++; $display("FAIL reset_all: got %h want %h", dut_all, exp_all());
        end
        vectors++;
        if (slots_o !== none_s) begin
            errors++; $display("FAIL reset_slots: got %h want %h", slots_o, none_s);
        end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_none_miss();
        for (int c = 0; c < TD; c++) begin
            apply(2'd0, (c == 0) ? 4'b0010 : 4'b0000);
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL none_miss cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
        end
        vectors++;
        if ({miss_o, hit_o, step_o, combo_o} !== {3'b101, 3'd0}) begin
            errors++; $display("FAIL none_miss_pulse: got miss=%b hit=%b step=%b combo=%0d want miss=1 hit=0 step=1 combo=0",
                               miss_o, hit_o, step_o, combo_o);
        end
    endtask

    task automatic test_scroll();
        int codes[5] = '{20, 16, 20, 20, 17};
        int k;
        k = 0;
        hard_reset();
        for (int c = 0; c < 5*TD; c++) begin
            apply(2'd0, 4'b0000);
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL scroll cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
            if (step_o === 1'b1 && k < 5) begin
                vectors++;
                if (slots_o[5*NS-1 -: 5] !== 5'(codes[k])) begin
                    errors++; $display("FAIL scroll_code %0d: got %0d want %0d", k, slots_o[5*NS-1 -: 5], codes[k]);
                end
                k++;
            end
        end
        vectors++;
        if (k !== 5) begin
            errors++; $display("FAIL scroll_steps: got %0d want 5", k);
        end
        vectors++;
        if (slots_o !== {5'd17, 5'd20, 5'd20, 5'd16}) begin
            errors++; $display("FAIL scroll_slots: got %h want %h", slots_o, {5'd17, 5'd20, 5'd20, 5'd16});
        end
    endtask

    task automatic test_hit();
        logic [3:0] seq[TD] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000};
        for (int c = 0; c < TD; c++) begin
            apply(2'd0, seq[c]);
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL hit cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
        end
        vectors++;
        if ({hit_o, miss_o, combo_o, max_combo_o} !== {2'b10, 3'd1, 3'd1}) begin
            errors++; $display("FAIL hit_result: got hit=%b miss=%b combo=%0d max=%0d want hit=1 miss=0 combo=1 max=1",
                               hit_o, miss_o, combo_o, max_combo_o);
        end
    endtask

    task automatic test_reset_state();
        apply(2'd2, 4'b0000);
        vectors++;
        if ({slots_o, combo_o, max_combo_o} !== {{NS{5'd20}}, 3'd0, 3'd1}) begin
            errors++; $display("FAIL rst_state: got slots=%h combo=%0d max=%0d want slots=all 20 combo=0 max=1",
                               slots_o, combo_o, max_combo_o);
        end
        for (int c = 0; c < 2*TD; c++) begin
            apply(2'd0, 4'b0000);
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL rst_state cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
            if (c == TD-1 || c == 2*TD-1) begin
                vectors++;
                if (slots_o[5*NS-1 -: 5] !== ((c == TD-1) ? 5'd20 : 5'd16)) begin
                    errors++; $display("FAIL rst_reseed cyc %0d: got %0d want %0d", c, slots_o[5*NS-1 -: 5],
                                       (c == TD-1) ? 20 : 16);
                end
            end
        end
    endtask

    task automatic test_pause();
        int n;
        apply(2'd0, 4'b0000);
        apply(2'd0, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            apply(($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, 4'($urandom_range(1, 15)));
            vectors++;
            if (dut_all !== exp_all() || step_o !== 1'b0) begin
                errors++; $display("FAIL pause cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
        end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            apply(2'd0, 4'b0000);
            n++;
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL pause_resume cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
            if (step_o === 1'b1) break;
        end
        vectors++;
        if (n !== TD-2 || step_o !== 1'b1 || miss_o !== 1'b0) begin
            errors++; $display("FAIL pause_remaining: got cycles=%0d step=%b miss=%b want cycles=%0d step=1 miss=0",
                               n, step_o, miss_o, TD-2);
        end
    endtask

    task automatic test_miss();
        hard_reset();
        for (int c = 0; c < 6*TD; c++) begin
            apply(2'd0, (c == 6*TD-1) ? 4'b1000 : 4'b0000);
            vectors++;
            if (dut_all !== exp_all()) begin
                errors++; $display("FAIL miss cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
        end
        vectors++;
        if ({miss_o, hit_o, combo_o} !== {2'b10, 3'd0}) begin
            errors++; $display("FAIL miss_result: got miss=%b hit=%b combo=%0d want miss=1 hit=0 combo=0",
                               miss_o, hit_o, combo_o);
        end
    endtask

    task automatic test_random();
        int r;
        logic [1:0] st;
        logic [3:0] b;
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            st = (r < 88) ? 2'd0 : (r < 95) ? 2'd1 : (r < 99) ? 2'd3 : 2'd2;
            if (m_cnt == 1 && $urandom_range(0, 9) != 0) b = 4'(mask_of(m_slots[0]));
            else if ($urandom_range(0, 29) == 0) b = 4'($urandom_range(1, 15));
            else b = 4'b0000;
            apply(st, b);
            vectors++;
            if (dut_all !== exp_all() || (hit_o & miss_o) !== 1'b0) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", c, dut_all, exp_all());
            end
            if ($urandom_range(0, 299) == 0) begin
                #2;
                arst = 1'b1;
                model_arst();
                #1;
                vectors++;
                if (dut_all !== exp_all()) begin
                    errors++; $display("FAIL random_arst cyc %0d: got %h want %h", c, dut_all, exp_all());
                end
                arst = 1'b0;
            end
        end
        vectors++;
        if (m_max !== (1 << CB) - 1 && max_combo_o !== CB'(m_max)) begin
            errors++; $display("FAIL random_max: got %0d want %0d", max_combo_o, m_max);
        end
    endtask

    initial begin
        test_reset();
        test_none_miss();
        test_scroll();
        test_hit();
        test_reset_state();
        test_pause();
        test_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
